// File: rtl/mips_pkg.sv
// ============================================================================
// Module   : mips_pkg
// Brief    : Shared widths and constants for the MIPS pipeline stages.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pkg;
    localparam int          SIZE      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam int          PC_STEP   = 4;
    localparam int          IF_ID_W   = 2 * SIZE;
endpackage : mips_pkg

`default_nettype wire

// File: rtl/instr_mem.sv
// ============================================================================
// Module   : instr_mem
// Brief    : Word-addressed instruction store, sync write / async read.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_mem #(
    parameter int SIZE   = 32,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [SIZE-1:0]   wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [SIZE-1:0]   rdata
);

    logic [SIZE-1:0] r_mem [DEPTH];

    // Contents are deliberately not reset; they are preloaded by the host.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule : instr_mem

`default_nettype wire

// File: rtl/if_stage.sv
// ============================================================================
// Module   : if_stage
// Brief    : Instruction fetch: PC register, next-PC select, IF_ID register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_stage #(
    parameter int SIZE       = mips_pkg::SIZE,
    parameter int IMEM_DEPTH = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              branch_taken,
    input  logic [SIZE-1:0]   branch_target,
    input  logic              imem_we,
    input  logic [SIZE-1:0]   imem_waddr,
    input  logic [SIZE-1:0]   imem_wdata,
    output logic [SIZE-1:0]   pc,
    output logic [2*SIZE-1:0] IF_ID,
    output logic              if_id_valid
);
    import mips_pkg::*;

    localparam int              c_addr_w = $clog2(IMEM_DEPTH);
    localparam logic [SIZE-1:0] c_nop    = SIZE'(NOP_INSTR);

    logic [SIZE-1:0]   r_pc;
    logic [SIZE-1:0]   w_pc_plus4;
    logic [SIZE-1:0]   w_instr;
    logic [2*SIZE-1:0] r_if_id;
    logic              r_valid;
    logic              w_unused;

    assign w_pc_plus4 = r_pc + SIZE'(PC_STEP);

    instr_mem #(
        .SIZE   (SIZE),
        .DEPTH  (IMEM_DEPTH),
        .ADDR_W (c_addr_w)
    ) u_imem (
        .clk   (clk),
        .we    (imem_we),
        .waddr (imem_waddr[c_addr_w+1:2]),
        .wdata (imem_wdata),
        .raddr (r_pc[c_addr_w+1:2]),
        .rdata (w_instr)
    );

    // A redirect overrides stall so a taken branch is never lost.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc <= '0;
        end else if (branch_taken) begin
            r_pc <= {branch_target[SIZE-1:2], 2'b00};
        end else if (!stall) begin
            r_pc <= w_pc_plus4;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_if_id <= '0;
            r_valid <= 1'b0;
        end else if (flush) begin
            r_if_id <= {{SIZE{1'b0}}, c_nop};
            r_valid <= 1'b0;
        end else if (!stall) begin
            r_if_id <= {w_pc_plus4, w_instr};
            r_valid <= 1'b1;
        end
    end

    // Byte-offset and out-of-range address bits are intentionally ignored.
    assign w_unused = &{1'b0, imem_waddr[SIZE-1:c_addr_w+2], imem_waddr[1:0],
                        branch_target[1:0]};

    assign pc          = r_pc;
    assign IF_ID       = r_if_id;
    assign if_id_valid = r_valid;

endmodule : if_stage

`default_nettype wire
